// File: rtl/adder_stream_pkg.sv
// Shared definitions for the adder stream blocks: default sample width,
// accumulator FSM states and a width-parameterised saturating add.
package adder_stream_pkg;

   // Sample width produced by the 8-bit stream adder (8 bits + carry).
   localparam int IN_W_DEF = 9;

   typedef enum logic {
      ACCUM = 1'b0,
      EMIT  = 1'b1
   } state_t;

   // Unsigned add of two values no wider than 64 bits, clamped at 2^w-1.
   // Callers cast the result down to their own width.
   function automatic logic [63:0] sat_add(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input int unsigned  w);
      logic [64:0] s;
      logic [64:0] mx;
      s  = {1'b0, a} + {1'b0, b};
      mx = (65'd1 << w) - 65'd1;
      return (s > mx) ? mx[63:0] : s[63:0];
   endfunction

endpackage

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums up to COUNT samples (or fewer, closed by i_last)
// from the adder stream and emits the frame total with its sample count.
// Optional build macro SUM_ACCUMULATOR_SATURATE_EN: saturating accumulation
// with a sticky per-frame clamp flag on o_sat; without it the add wraps and
// o_sat is tied 0.
module sum_accumulator
   import adder_stream_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int COUNT = 4,
   parameter int ACC_W = 11,
   localparam int LEN_W = $clog2(COUNT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  i_data,
   input  logic             i_valid,
   input  logic             i_last,
   output logic             i_ready,
   output logic [ACC_W-1:0] o_data,
   output logic [LEN_W-1:0] o_len,
   output logic             o_sat,
   output logic             o_valid,
   input  logic             o_ready
);

   state_t           state, state_nxt;
   logic [ACC_W-1:0] acc, acc_nxt;
   logic [LEN_W-1:0] cnt, cnt_nxt;
   logic [ACC_W-1:0] data_nxt;
   logic [LEN_W-1:0] len_nxt;
   logic             valid_nxt;

   logic             accept;
   logic             close;
   logic [ACC_W-1:0] base;
   logic [ACC_W-1:0] din;
   logic [ACC_W-1:0] acc_sum;
   logic [LEN_W-1:0] cnt_inc;

   // Ready depends only on state and reset, never on i_valid or o_ready.
   assign i_ready = (state == ACCUM) && !rst;
   assign accept  = i_valid && i_ready;

   // First sample of a frame loads rather than adds, so a stale acc never
   // leaks into a new frame.
   assign base    = (cnt == '0) ? '0 : acc;
   assign din     = ACC_W'(i_data);
   assign cnt_inc = cnt + LEN_W'(1);
   assign close   = (cnt_inc == LEN_W'(COUNT)) || i_last;

`ifdef SUM_ACCUMULATOR_SATURATE_EN
   logic sat_run, sat_run_nxt;
   logic sat_cur;
   logic sat_q, sat_q_nxt;
   logic clamp;

   assign acc_sum = ACC_W'(sat_add(64'(base), 64'(din), ACC_W));
   assign clamp   = (({1'b0, base} + {1'b0, din}) > {1'b0, {ACC_W{1'b1}}});
   // Sticky flag restarts with the frame, so it only covers this frame's adds.
   assign sat_cur = ((cnt == '0) ? 1'b0 : sat_run) | clamp;
   assign o_sat   = sat_q;
`else
   assign acc_sum = base + din;
   assign o_sat   = 1'b0;
`endif

   // Next-state and next-datapath decode; everything holds by default.
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      data_nxt  = o_data;
      len_nxt   = o_len;
      valid_nxt = o_valid;
`ifdef SUM_ACCUMULATOR_SATURATE_EN
      sat_run_nxt = sat_run;
      sat_q_nxt   = sat_q;
`endif
      case (state)
         ACCUM: begin
            if (accept) begin
               acc_nxt = acc_sum;
               cnt_nxt = cnt_inc;
`ifdef SUM_ACCUMULATOR_SATURATE_EN
               sat_run_nxt = sat_cur;
`endif
               if (close) begin
                  state_nxt = EMIT;
                  data_nxt  = acc_sum;
                  len_nxt   = cnt_inc;
                  valid_nxt = 1'b1;
`ifdef SUM_ACCUMULATOR_SATURATE_EN
                  sat_q_nxt = sat_cur;
`endif
               end
            end
         end
         EMIT: begin
            // Output fields stay frozen until the consumer takes them.
            if (o_ready) begin
               state_nxt = ACCUM;
               valid_nxt = 1'b0;
               cnt_nxt   = '0;
               acc_nxt   = '0;
`ifdef SUM_ACCUMULATOR_SATURATE_EN
               sat_run_nxt = 1'b0;
`endif
            end
         end
         default: state_nxt = ACCUM;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ACCUM;
      else     state <= state_nxt;
   end

   // Accumulator, counter and output registers; reset drops any partial or
   // pending frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= '0;
         cnt     <= '0;
         o_data  <= '0;
         o_len   <= '0;
         o_valid <= 1'b0;
      end else begin
         acc     <= acc_nxt;
         cnt     <= cnt_nxt;
         o_data  <= data_nxt;
         o_len   <= len_nxt;
         o_valid <= valid_nxt;
      end
   end

`ifdef SUM_ACCUMULATOR_SATURATE_EN
   // Clamp tracking: running flag for the open frame, latched copy for output.
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_run <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         sat_run <= sat_run_nxt;
         sat_q   <= sat_q_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator (ACC_W=10 so overflow is reachable).
// Drivers act at posedge+1; all observation happens on the falling edge.
module tb_sum_accumulator;
   localparam int IN_W  = 9;
   localparam int COUNT = 4;
   localparam int ACC_W = 10;
   localparam int LEN_W = $clog2(COUNT + 1);
   localparam int MX    = (1 << ACC_W) - 1;

   typedef struct {
      logic [ACC_W-1:0] d;
      logic [LEN_W-1:0] l;
      logic             s;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [IN_W-1:0]  i_data = '0;
   logic             i_valid = 1'b0;
   logic             i_last = 1'b0;
   logic             i_ready;
   logic [ACC_W-1:0] o_data;
   logic [LEN_W-1:0] o_len;
   logic             o_sat;
   logic             o_valid;
   logic             o_ready;
   logic             rand_mode = 1'b0;
   logic             ordy_dir = 1'b1;
   logic             ordy_rnd = 1'b1;

   exp_t sbq[$];
   int   vecs = 0, miss = 0;
   int   m_sum = 0, m_cnt = 0;
   int   n_out = 0, n_exp = 0;

   assign o_ready = rand_mode ? ordy_rnd : ordy_dir;

   sum_accumulator #(.IN_W(IN_W), .COUNT(COUNT), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
      .i_ready(i_ready), .o_data(o_data), .o_len(o_len), .o_sat(o_sat),
      .o_valid(o_valid), .o_ready(o_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1 ordy_rnd = ($urandom_range(0, 2) != 0);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Reference model: running unsigned sum, closes on COUNT or last.
   task automatic model_acc(input int d, input bit l);
      exp_t e;
      m_sum += d;
      m_cnt++;
      if (m_cnt == COUNT || l) begin
`ifdef SUM_ACCUMULATOR_SATURATE_EN
         e.d = (m_sum > MX) ? ACC_W'(MX) : ACC_W'(m_sum);
         e.s = (m_sum > MX);
`else
         e.d = ACC_W'(m_sum);
         e.s = 1'b0;
`endif
         e.l = LEN_W'(m_cnt);
         sbq.push_back(e);
         n_exp++;
         m_sum = 0;
         m_cnt = 0;
      end
   endtask

   // Present one sample until it is accepted (bounded).
   task automatic send(input int d, input bit l);
      int n = 0;
      bit ok = 1'b0;
      i_data  = IN_W'(d);
      i_last  = l;
      i_valid = 1'b1;
      while (!ok) begin
         @(negedge clk);
         ok = i_ready;
         sync();
         if (!ok) begin
            n++;
            if (n > 200) begin
               vecs++;
               miss++;
               $display("FAIL send_timeout: got no accept for sample %0d, expected accept", d);
               break;
            end
         end
      end
      i_valid = 1'b0;
      i_last  = 1'b0;
      if (ok) model_acc(d, l);
   endtask

   // Monitor: every output handshake is compared with the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && o_valid && o_ready) begin
         n_out++;
         if (sbq.size() == 0) begin
            vecs++;
            miss++;
            $display("FAIL unexpected_output: got data %0d, expected no output", o_data);
         end else begin
            e = sbq.pop_front();
            chk("out_data", 32'(o_data), 32'(e.d));
            chk("out_len",  32'(o_len),  32'(e.l));
            chk("out_sat",  32'(o_sat),  32'(e.s));
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset state
      sync(); sync();
      @(negedge clk);
      chk("rst_o_valid", 32'(o_valid), 0);
      chk("rst_o_data",  32'(o_data),  0);
      chk("rst_o_len",   32'(o_len),   0);
      chk("rst_o_sat",   32'(o_sat),   0);
      chk("rst_i_ready", 32'(i_ready), 0);
      sync();
      rst = 1'b0;
      @(negedge clk);
      chk("idle_i_ready", 32'(i_ready), 1);
      sync();

      // Full frame of four, single-cycle o_valid right after the 4th accept
      send(10, 0); send(20, 0); send(30, 0); send(40, 0);
      @(negedge clk);
      chk("f4_valid", 32'(o_valid), 1);
      chk("f4_data",  32'(o_data),  100);
      chk("f4_len",   32'(o_len),   4);
      chk("f4_i_ready", 32'(i_ready), 0);
      sync();
      @(negedge clk);
      chk("f4_valid_drop", 32'(o_valid), 0);
      sync();

      // Early close, then next frame starts from zero
      send(5, 0); send(7, 1);
      @(negedge clk);
      chk("f2_data", 32'(o_data), 12);
      chk("f2_len",  32'(o_len),  2);
      sync();
      send(3, 1);
      @(negedge clk);
      chk("f1_data", 32'(o_data), 3);
      chk("f1_len",  32'(o_len),  1);
      sync();

      // Output stall: fields frozen, no input consumed
      ordy_dir = 1'b0;
      send(100, 0); send(200, 1);
      i_data = 9'd7; i_last = 1'b1; i_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_valid",   32'(o_valid), 1);
         chk("stall_data",    32'(o_data),  300);
         chk("stall_len",     32'(o_len),   2);
         chk("stall_i_ready", 32'(i_ready), 0);
         sync();
      end
      ordy_dir = 1'b1;
      send(7, 1);
      sync();

      // i_last on the COUNT-th sample closes once
      send(1, 0); send(2, 0); send(3, 0); send(4, 1);
      @(negedge clk);
      chk("lastcnt_data", 32'(o_data), 10);
      chk("lastcnt_len",  32'(o_len),  4);
      sync(); sync();

      // i_last without i_valid is ignored; i_valid gaps keep the frame
      send(6, 0);
      i_last = 1'b1;
      sync(); sync();
      i_last = 1'b0;
      send(6, 1);
      @(negedge clk);
      chk("gap_data", 32'(o_data), 12);
      chk("gap_len",  32'(o_len),  2);
      sync();

      // Overflow at ACC_W=10
      send(511, 0); send(511, 0); send(511, 0); send(511, 0);
      @(negedge clk);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
      chk("ovf_data", 32'(o_data), 1023);
      chk("ovf_sat",  32'(o_sat),  1);
`else
      chk("ovf_data", 32'(o_data), 1020);
      chk("ovf_sat",  32'(o_sat),  0);
`endif
      sync();

      // Reset mid-frame discards the partial sum
      send(9, 0); send(9, 0);
      rst = 1'b1;
      sync();
      m_sum = 0; m_cnt = 0;
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_valid", 32'(o_valid), 0);
      sync();
      send(1, 0); send(1, 0); send(1, 0); send(1, 0);
      @(negedge clk);
      chk("rstmid_data", 32'(o_data), 4);
      chk("rstmid_len",  32'(o_len),  4);
      sync();

      // Reset during EMIT drops the pending result
      ordy_dir = 1'b0;
      send(5, 1);
      void'(sbq.pop_back());
      n_exp--;
      rst = 1'b1;
      sync();
      rst = 1'b0;
      @(negedge clk);
      chk("rstemit_valid", 32'(o_valid), 0);
      sync();
      ordy_dir = 1'b1;

      // Random gaps and back-pressure over many frames
      rand_mode = 1'b1;
      for (int f = 0; f < 1000; f++) begin
         int len;
         len = $urandom_range(1, COUNT);
         for (int k = 0; k < len; k++) begin
            int gap;
            bit lst;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) sync();
            lst = (k == len - 1) && ((len < COUNT) || ($urandom_range(0, 1) == 1));
            send($urandom_range(0, 511), lst);
         end
      end
      rand_mode = 1'b0;

      // Drain and account for every frame
      n = 0;
      while (sbq.size() > 0 && n < 100) begin
         sync();
         n++;
      end
      sync(); sync();
      chk("drain_empty", 32'(sbq.size()), 0);
      chk("out_count",   32'(n_out), 32'(n_exp));
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
